rx_gate_sched: RTL and testbench

RX_GATE_SCHED -- requirements
Module: rx_gate_sched

---
 rtl/rx_gate_sched.sv | 206 ++++++++++++++++++++
 tb/tb_rx_gate_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_gate_sched.sv
// RX write-gate scheduler: after each accepted sync it opens nwin sample windows on the
// decimated strobe. Each window holds the gate open until the buffer finishes its frame.
module rx_gate_sched #(
  parameter int CNT_W = 16
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_in,
  input  logic             rxstrobe,
  input  logic [3:0]       buf_phase,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [2:0]       cfg_nwin,
  input  logic             clear_status,
  output logic             gate_enable,
  output logic [2:0]       win_idx,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             sync_miss
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_OPEN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             sync_prev_q, sync_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]       win_idx_q, win_idx_d;
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             miss_q, miss_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] delay_sh_q, delay_sh_d;
  logic [CNT_W-1:0] width_sh_q, width_sh_d;
  logic [CNT_W-1:0] gap_sh_q, gap_sh_d;
  logic [2:0]       nwin_sh_q, nwin_sh_d;

  logic             sync_edge;
  logic             cfg_valid;
  logic             last_win;
  logic [CNT_W-1:0] skip_target;

  assign sync_edge   = sync_in & ~sync_prev_q;
  assign cfg_valid   = (cfg_width != CNT_ZERO) && (cfg_nwin != 3'd0);
  assign last_win    = (win_idx_q == (nwin_sh_q - 3'd1));
  assign skip_target = (state_q == ST_DELAY) ? delay_sh_q : gap_sh_q;

  // Next-state, counter, gate and status computation.
  always_comb begin
    state_d      = state_q;
    sync_prev_d  = sync_in;
    cnt_d        = cnt_q;
    sample_cnt_d = sample_cnt_q;
    win_idx_d    = win_idx_q;
    gate_d       = gate_q;
    miss_d       = miss_q;
    abort_d      = abort_q;
    delay_sh_d   = delay_sh_q;
    width_sh_d   = width_sh_q;
    gap_sh_d     = gap_sh_q;
    nwin_sh_d    = nwin_sh_q;

    // A new sync while a sequence runs is only recorded; setting beats clearing.
    if (sync_edge && (state_q != ST_IDLE)) begin
      miss_d = 1'b1;
    end else if (clear_status) begin
      miss_d = 1'b0;
    end else begin
      miss_d = miss_q;
    end

    case (state_q)
      ST_IDLE: begin
        gate_d = 1'b0;
        if (sync_edge && enable && cfg_valid) begin
          delay_sh_d   = cfg_delay;
          width_sh_d   = cfg_width;
          gap_sh_d     = cfg_gap;
          nwin_sh_d    = cfg_nwin;
          cnt_d        = CNT_ZERO;
          sample_cnt_d = CNT_ZERO;
          win_idx_d    = 3'd0;
          abort_d      = 1'b0;
          state_d      = ST_DELAY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // DELAY and GAP differ only in which shadowed skip count they wait out.
      ST_DELAY, ST_GAP: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rxstrobe) begin
          if (cnt_q == skip_target) begin
            gate_d       = 1'b1;
            sample_cnt_d = CNT_ONE;
            cnt_d        = CNT_ZERO;
            if (width_sh_q == CNT_ONE) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_OPEN;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_OPEN: begin
        if (!enable) begin
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (rxstrobe) begin
          sample_cnt_d = sample_cnt_q + CNT_ONE;
          if ((sample_cnt_q + CNT_ONE) == width_sh_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_OPEN;
          end
        end else begin
          state_d = ST_OPEN;
        end
      end

      // The gate stays open until the buffer reports no frame in flight.
      ST_DRAIN: begin
        if (buf_phase == 4'd0) begin
          gate_d = 1'b0;
          if (abort_q || !enable || last_win) begin
            state_d = ST_IDLE;
          end else begin
            win_idx_d    = win_idx_q + 3'd1;
            cnt_d        = CNT_ZERO;
            sample_cnt_d = CNT_ZERO;
            state_d      = ST_GAP;
          end
        end else if (!enable) begin
          abort_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        gate_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync_prev_q  <= sync_in;
      cnt_q        <= CNT_ZERO;
      sample_cnt_q <= CNT_ZERO;
      win_idx_q    <= 3'd0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      miss_q       <= 1'b0;
      abort_q      <= 1'b0;
      delay_sh_q   <= CNT_ZERO;
      width_sh_q   <= CNT_ZERO;
      gap_sh_q     <= CNT_ZERO;
      nwin_sh_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      sync_prev_q  <= sync_prev_d;
      cnt_q        <= cnt_d;
      sample_cnt_q <= sample_cnt_d;
      win_idx_q    <= win_idx_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
      miss_q       <= miss_d;
      abort_q      <= abort_d;
      delay_sh_q   <= delay_sh_d;
      width_sh_q   <= width_sh_d;
      gap_sh_q     <= gap_sh_d;
      nwin_sh_q    <= nwin_sh_d;
    end
  end

  assign gate_enable = gate_q;
  assign win_idx     = win_idx_q;
  assign sample_cnt  = sample_cnt_q;
  assign busy        = busy_q;
  assign sync_miss   = miss_q;

endmodule

// File: tb/tb_rx_gate_sched.sv
// Bench for rx_gate_sched: directed scenarios plus random traffic, checked every cycle
// against a countdown-based model of the window schedule.
module tb_rx_gate_sched;
  localparam int CNT_W = 16;

  logic             rxclk = 1'b0;
  logic             reset, enable, sync_in, rxstrobe, clear_status;
  logic [3:0]       buf_phase;
  logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap;
  logic [2:0]       cfg_nwin;
  logic             gate_enable, busy, sync_miss;
  logic [2:0]       win_idx;
  logic [CNT_W-1:0] sample_cnt;

  always #5 rxclk = ~rxclk;

  rx_gate_sched #(.CNT_W(CNT_W)) dut (
    .rxclk(rxclk), .reset(reset), .enable(enable), .sync_in(sync_in),
    .rxstrobe(rxstrobe), .buf_phase(buf_phase), .cfg_delay(cfg_delay),
    .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_nwin(cfg_nwin),
    .clear_status(clear_status), .gate_enable(gate_enable), .win_idx(win_idx),
    .sample_cnt(sample_cnt), .busy(busy), .sync_miss(sync_miss)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 = skipping strobes, 1 = collecting samples, 2 = draining.
  bit m_act, m_gate, m_miss, m_abort, m_prev;
  int m_ph, m_skip, m_left, m_samp, m_win;
  int s_delay, s_width, s_gap, s_nwin;

  task automatic model_step();
    bit edge_s;
    edge_s = sync_in && !m_prev;
    if (reset) begin
      m_act = 0; m_ph = 0; m_skip = 0; m_left = 0; m_samp = 0; m_win = 0;
      m_gate = 0; m_miss = 0; m_abort = 0;
      s_delay = 0; s_width = 0; s_gap = 0; s_nwin = 0;
    end else begin
      if (edge_s && m_act) m_miss = 1;
      else if (clear_status) m_miss = 0;
      if (!m_act) begin
        if (edge_s && enable && cfg_width != 0 && cfg_nwin != 0) begin
          s_delay = int'(cfg_delay); s_width = int'(cfg_width);
          s_gap = int'(cfg_gap); s_nwin = int'(cfg_nwin);
          m_act = 1; m_ph = 0; m_skip = s_delay; m_win = 0; m_samp = 0; m_abort = 0;
        end
      end else if (m_ph == 0) begin
        if (!enable) m_act = 0;
        else if (rxstrobe) begin
          if (m_skip == 0) begin
            m_gate = 1; m_samp = 1; m_left = s_width - 1;
            m_ph = (m_left == 0) ? 2 : 1;
          end else m_skip--;
        end
      end else if (m_ph == 1) begin
        if (!enable) begin m_ph = 2; m_abort = 1; end
        else if (rxstrobe) begin
          m_samp++; m_left--;
          if (m_left == 0) m_ph = 2;
        end
      end else begin
        if (buf_phase == 4'd0) begin
          m_gate = 0;
          if (m_abort || !enable || m_win == s_nwin - 1) m_act = 0;
          else begin m_win++; m_samp = 0; m_ph = 0; m_skip = s_gap; end
        end else if (!enable) m_abort = 1;
      end
    end
    m_prev = sync_in;
  endtask

  // Strobe / buffer-phase generator state.
  int period = 4, nch = 2, ph = 0, cyc = 0;
  bit rand_strobe = 0, ovr = 0;
  logic [3:0] ovr_val = 4'd0;

  task automatic step();
    if (rand_strobe) rxstrobe = ($urandom_range(0, 3) == 0);
    else rxstrobe = (cyc % period == period - 1);
    if (rxstrobe) ph = 1;
    else if (ph != 0) ph = (ph >= nch) ? 0 : ph + 1;
    buf_phase = ovr ? ovr_val : 4'(ph);
    cyc++;
    model_step();
    @(posedge rxclk);
    #1;
    check("gate_enable", 32'(gate_enable), 32'(m_gate));
    check("busy", 32'(busy), 32'(m_act));
    check("win_idx", 32'(win_idx), 32'(m_win));
    check("sample_cnt", 32'(sample_cnt), 32'(m_samp));
    check("sync_miss", 32'(sync_miss), 32'(m_miss));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1; step();
    sync_in = 1'b0; step();
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int n);
    cfg_delay = 16'(d); cfg_width = 16'(w); cfg_gap = 16'(g); cfg_nwin = 3'(n);
  endtask

  // Step until the model reaches the wanted phase (win < 0 means any window).
  task automatic wait_ph(input int want, input int win, input string tag);
    int n = 0;
    while (!(m_act && m_ph == want && (win < 0 || m_win == win)) && n < 300) begin
      step(); n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for phase %0d", tag, want);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; sync_in = 1'b0; rxstrobe = 1'b0; clear_status = 1'b0;
    buf_phase = 4'd0;
    set_cfg(0, 0, 0, 0);
    run(3);
    check("rst_gate", 32'(gate_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_samp", 32'(sample_cnt), 32'd0);
    reset = 1'b0;
    run(2);

    // Single window with skipped strobes and a 2-channel buffer.
    set_cfg(2, 3, 0, 1);
    pulse_sync();
    run(60);
    check("s1_samp", 32'(sample_cnt), 32'd3);
    check("s1_busy", 32'(busy), 32'd0);

    // Three windows separated by one skipped strobe.
    set_cfg(0, 2, 1, 3);
    pulse_sync();
    run(90);
    check("s2_win", 32'(win_idx), 32'd2);
    check("s2_busy", 32'(busy), 32'd0);

    // Syncs during a running sequence, one coinciding with clear_status.
    set_cfg(1, 4, 1, 2);
    pulse_sync();
    wait_ph(1, 0, "s3_open");
    pulse_sync();
    check("s3_miss1", 32'(sync_miss), 32'd1);
    clear_status = 1'b1; sync_in = 1'b1; step();
    clear_status = 1'b0; sync_in = 1'b0; step();
    check("s3_miss2", 32'(sync_miss), 32'd1);
    run(100);
    check("s3_win", 32'(win_idx), 32'd1);
    check("s3_samp", 32'(sample_cnt), 32'd4);
    clear_status = 1'b1; step(); clear_status = 1'b0;

    // Buffer held busy during DRAIN.
    set_cfg(0, 1, 0, 1);
    pulse_sync();
    wait_ph(2, 0, "s4_drain");
    ovr = 1; ovr_val = 4'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      check("drain_hold", 32'(gate_enable), 32'd1);
    end
    ovr_val = 4'd0; step();
    check("drain_drop", 32'(gate_enable), 32'd0);
    ovr = 0; ph = 0;
    run(10);

    // enable dropped in GAP, then in OPEN.
    set_cfg(0, 1, 3, 3);
    pulse_sync();
    wait_ph(0, 1, "s5_gap");
    enable = 1'b0; step(); enable = 1'b1;
    check("gap_abort_busy", 32'(busy), 32'd0);
    check("gap_abort_gate", 32'(gate_enable), 32'd0);
    run(10);
    set_cfg(0, 5, 0, 3);
    pulse_sync();
    wait_ph(1, 0, "s5_open");
    enable = 1'b0; step(); enable = 1'b1;
    check("open_abort_gate", 32'(gate_enable), 32'd1);
    run(30);
    check("open_abort_busy", 32'(busy), 32'd0);
    check("open_abort_win", 32'(win_idx), 32'd0);

    // Disabled configurations and blocked enable.
    set_cfg(0, 0, 0, 3); pulse_sync(); run(5);
    check("w0_busy", 32'(busy), 32'd0);
    set_cfg(0, 3, 0, 0); pulse_sync(); run(5);
    check("n0_busy", 32'(busy), 32'd0);
    set_cfg(0, 3, 0, 1); enable = 1'b0; pulse_sync(); run(5); enable = 1'b1;
    check("en0_busy", 32'(busy), 32'd0);

    // Reset in the middle of a window drops the gate immediately.
    set_cfg(0, 8, 0, 1);
    pulse_sync();
    wait_ph(1, 0, "s6_open");
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_gate", 32'(gate_enable), 32'd0);
    run(5);

    // Random traffic.
    rand_strobe = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        set_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4));
        nch = $urandom_range(1, 3);
      end
      sync_in      = ($urandom_range(0, 19) == 0);
      enable       = ($urandom_range(0, 199) != 0);
      clear_status = ($urandom_range(0, 49) == 0);
      reset        = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
